// File: rtl/out_port_buffer_pkg.sv
// Shared definitions for the CPU output-port buffer.
// Provides the CPU-side handshake FSM state encoding and the default data width / FIFO
// depth used when the buffer is integrated at the CPU top level.
package out_port_buffer_pkg;

  // Default geometry for CPU integration.
  localparam int unsigned OpbWidth = 16;
  localparam int unsigned OpbDepth = 8;
  localparam int unsigned OpbAw    = 3;

  // CPU-side handshake states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAck  = 2'd1,
    StHold = 2'd2
  } opb_state_e;

endpackage

// File: rtl/out_port_buffer_sync_fifo.sv
// Synchronous FIFO (sync_fifo) with register-array storage and first-word fall-through.
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    synchronous active-high reset; clears pointers and level, not the storage
//   push_i   write din_i this cycle (ignored when full)
//   pop_i    discard the head word this cycle (ignored when empty)
//   din_i    write data
//   dout_o   head word; 0 while empty
//   level_o  occupancy 0..DEPTH
//   full_o   level == DEPTH
//   empty_o  level == 0
module out_port_buffer_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [AW:0]      level_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned LevelW = AW + 1;
  localparam logic [AW:0] FullLevel = LevelW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_en, pop_en;

  assign full_o  = (level_q == FullLevel);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

  // Guards make overflow and underflow impossible regardless of the caller.
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  // Storage is never cleared, so mask the head to keep dev_data at 0 while empty.
  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;  // wraps modulo DEPTH (power of two)
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_en, pop_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/out_port_buffer.sv
// Output peripheral behind the CPU OUT path. Captures one word per CPU out_req, acknowledges
// it with a one-cycle out_ack, buffers it in a small FIFO and drains it to an external device
// over valid/ready. The CPU stalls (no ack) only while the FIFO is full.
// Ports:
//   clk_i        system clock, rising edge
//   rst_b_i      synchronous reset, asserted high (name kept from the CPU codebase)
//   out_req_i    CPU request, level, held until out_ack_o is seen
//   out_data_i   CPU word, valid while out_req_i=1
//   out_ack_o    one-cycle acknowledge, decoded from the state register
//   dev_data_o   head-of-FIFO word
//   dev_valid_o  FIFO non-empty
//   dev_ready_i  device accepts dev_data_o this cycle
//   level_o      occupancy 0..DEPTH
//   full_o       level == DEPTH
//   empty_o      level == 0
module out_port_buffer
  import out_port_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = OpbWidth,
  parameter int unsigned DEPTH = OpbDepth,
  parameter int unsigned AW    = OpbAw
) (
  input  logic             clk_i,
  input  logic             rst_b_i,
  input  logic             out_req_i,
  input  logic [WIDTH-1:0] out_data_i,
  output logic             out_ack_o,
  output logic [WIDTH-1:0] dev_data_o,
  output logic             dev_valid_o,
  input  logic             dev_ready_i,
  output logic [AW:0]      level_o,
  output logic             full_o,
  output logic             empty_o
);

  opb_state_e state_q, state_d;
  logic       push;
  logic       fifo_full, fifo_empty;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Full is judged on the current level; a same-cycle pop does not admit the word.
        if (out_req_i && !fifo_full) begin
          push    = 1'b1;
          state_d = StAck;
        end
      end
      StAck: begin
        state_d = out_req_i ? StHold : StIdle;
      end
      StHold: begin
        // Wait for the CPU to drop the request so one request is never captured twice.
        if (!out_req_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_b_i) state_q <= StIdle;
    else         state_q <= state_d;
  end

  assign out_ack_o = (state_q == StAck);

  out_port_buffer_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_b_i),
    .push_i  (push),
    .pop_i   (dev_ready_i),
    .din_i   (out_data_i),
    .dout_o  (dev_data_o),
    .level_o (level_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign dev_valid_o = !fifo_empty;
  assign full_o      = fifo_full;
  assign empty_o     = fifo_empty;

endmodule

// File: doc/out_port_buffer.md
Name: out_port_buffer

Overview:
- Output peripheral directly downstream of the CPU's OUT path.
- Consumes the CPU's out_req/out_data request and returns out_ack.
- Buffers words in a small synchronous FIFO and drains them to an external device over a valid/ready interface.
- Decouples OUT instruction latency from a slow device; the CPU stalls only when the buffer is full.

Parameters:
- WIDTH, 16, data word width; matches CPU out_data.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- AW, 3, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_b  in  1  reset; synchronous, active-high. Port keeps the codebase name, but asserted = 1.
- out_req  in  1  CPU output request; level, held until out_ack seen.
- out_data  in  WIDTH  CPU output word; valid while out_req=1.
- out_ack  out  1  registered one-cycle acknowledge to CPU.
- dev_data  out  WIDTH  head-of-FIFO word.
- dev_valid  out  1  FIFO non-empty.
- dev_ready  in  1  device accepts dev_data this cycle.
- level  out  AW+1  current occupancy, 0..DEPTH.
- full  out  1  level==DEPTH.
- empty  out  1  level==0.

Behaviour:
- Reset (rst_b=1 at clk edge) clears state, pointers and level.
  - Resulting outputs: out_ack=0, dev_valid=0, empty=1, full=0, level=0.
  - dev_data=0 after reset; FIFO storage is not cleared.
  - Reset mid-handshake abandons the pending word and any buffered words.
- CPU-side FSM has three states: IDLE, ACK, HOLD.
  - IDLE: when out_req=1 and full=0, write out_data into the FIFO this cycle and go to ACK. When out_req=1 and full=1, stay in IDLE with no write; the CPU stalls.
  - ACK: out_ack=1 for exactly this cycle; no write. Next state is HOLD if out_req=1, otherwise IDLE.
  - HOLD: wait for out_req=0, then go to IDLE; no write. This prevents a double-capture of one request.
- Latency:
  - out_ack rises 1 cycle after capture, i.e. 1 cycle after out_req when the buffer is not full.
  - A captured word is visible on dev_data/dev_valid in the cycle after capture when the FIFO was empty (registered write, first-word fall-through read).
- Device side:
  - A pop occurs on any cycle where dev_valid=1 and dev_ready=1.
  - dev_data holds the head word and is stable while dev_valid=1 and dev_ready=0.
  - dev_ready with empty=1 is ignored.
- Simultaneous push and pop: level is unchanged and both pointers advance.
- Full is evaluated on the current-cycle level. A push is refused when full even if a pop occurs in the same cycle; the push is retried next cycle.
- Pointers wrap modulo DEPTH.
- level increments on push only, decrements on pop only. It never exceeds DEPTH and never goes below 0.
- No overflow or underflow is possible by construction.
- out_data is sampled only in IDLE on the capture cycle; changes at other times are ignored.

Decomposition:
- Shared header:
  - FSM state encodings: IDLE=2'd0, ACK=2'd1, HOLD=2'd2.
  - Default WIDTH/DEPTH localparams used by CPU top-level integration.
- One sub-module: sync_fifo (WIDTH, DEPTH, AW).
  - Inputs: push, pop, din.
  - Outputs: dout, level, full, empty.
  - Register-array storage with first-word fall-through.
- The handshake FSM lives in out_port_buffer.

Test Plan:
- Reset check: drive rst_b=1 for 2 cycles with out_req=1 -> out_ack=0, dev_valid=0, level=0, empty=1 throughout.
- Single word:
  - out_req=1, out_data=16'h00A5, dev_ready=0 -> out_ack=1 exactly one cycle (cycle 2); dev_valid=1, dev_data=16'h00A5, level=1.
  - Then dev_ready=1 for one cycle -> level=0, dev_valid=0.
- No double capture: hold out_req=1 for 6 cycles after ack -> level stays 1, out_ack pulses once; FSM returns to IDLE only after out_req=0.
- Backpressure:
  - With dev_ready=0, push 8 words 16'h0001..16'h0008 -> full=1, level=8.
  - A 9th request (16'h0009) gets no out_ack.
  - Pulse dev_ready=1 once -> 16'h0001 popped; 16'h0009 accepted on the following cycle; ack follows; level=8.
- Simultaneous push/pop at level=3, dev_ready=1 during capture -> level stays 3; order out is preserved.
- Wrap and reset:
  - Stream 20 words with dev_ready toggling -> output sequence identical to input sequence.
  - Assert rst_b while level=5 and in ACK -> next cycle level=0, out_ack=0, dev_valid=0.
